// File: rtl/nyaya_dispatch.sv
// Nyaya dispatch: in-order instruction FIFO feeding a downstream 4-valued ALU
// through a fixed IDLE/ISSUE/EXEC/WB sequence, with a 2-bit-per-entry register file.
module nyaya_dispatch #(
    parameter int DEPTH = 4,
    parameter int NREG  = 8,
    localparam int AW = $clog2(NREG),
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    // Input handshake: an instruction transfers on a rising edge where
    // in_valid and in_ready are both high; in_ready depends only on occupancy.
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_opcode,
    input  logic [AW-1:0] in_ra,
    input  logic [AW-1:0] in_rb,
    input  logic [AW-1:0] in_rd,
    input  logic          flush,
    output logic [1:0]    alu_op_a,
    output logic [1:0]    alu_op_b,
    output logic [2:0]    alu_opcode,
    input  logic [1:0]    alu_result,
    input  logic          alu_loop_flag,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [1:0]    ext_data,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_data,
    output logic          busy,
    output logic [CW-1:0] fifo_count,
    output logic          loop_sticky,
    output logic [7:0]    loop_count,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]    opcode;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [AW-1:0] rd;
    } instr_t;

    state_t        state_q, state_d;
    instr_t        fifo_q [DEPTH];
    instr_t        head;
    instr_t        in_instr;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    rf_q [NREG];
    logic [1:0]    rf_d [NREG];
    logic [1:0]    rf_view [1 << AW];
    logic [AW-1:0] rd_lat_q, rd_lat_d;
    logic [1:0]    op_a_q, op_a_d;
    logic [1:0]    op_b_q, op_b_d;
    logic [2:0]    opcode_q, opcode_d;
    logic          loop_sticky_q, loop_sticky_d;
    logic [7:0]    loop_count_q, loop_count_d;
    logic          push, pop, wb, ext_ok;

    assign in_instr = {in_opcode, in_ra, in_rb, in_rd};
    assign head     = fifo_q[rd_ptr_q];

    assign in_ready = (count_q < CW'(DEPTH));
    assign busy     = (state_q != S_IDLE);
    assign push     = in_valid && in_ready && !flush;
    assign pop      = (state_q == S_IDLE) && (count_q != '0) && !flush;
    // A flush landing in WB aborts the instruction, so nothing is written back.
    assign wb       = (state_q == S_WB) && !flush;
    assign ext_ok   = ext_we && !busy;

    // Addresses beyond NREG read as ASATYA when NREG is not a power of two.
    for (genvar g = 0; g < (1 << AW); g++) begin : g_view
        if (g < NREG) begin : g_live
            assign rf_view[g] = rf_q[g];
        end else begin : g_pad
            assign rf_view[g] = 2'b00;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (pop) state_d = S_ISSUE;
                S_ISSUE: state_d = S_EXEC;
                S_EXEC:  state_d = S_WB;
                S_WB:    state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= in_instr;
    end

    // Operands are captured from the pre-edge register file, so a host write
    // landing on the pop edge is not seen by the popped instruction.
    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        opcode_d = opcode_q;
        rd_lat_d = rd_lat_q;
        if (pop) begin
            op_a_d   = rf_view[head.ra];
            op_b_d   = rf_view[head.rb];
            opcode_d = head.opcode;
            rd_lat_d = head.rd;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb) begin
            for (int i = 0; i < NREG; i++) begin
                if (rd_lat_q == AW'(i)) rf_d[i] = alu_result;
            end
        end else if (ext_ok) begin
            for (int i = 0; i < NREG; i++) begin
                if (ext_addr == AW'(i)) rf_d[i] = ext_data;
            end
        end
    end

    always_comb begin
        loop_sticky_d = loop_sticky_q;
        loop_count_d  = loop_count_q;
        if (wb && alu_loop_flag) begin
            loop_sticky_d = 1'b1;
            if (loop_count_q != 8'hFF) loop_count_d = loop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rd_lat_q      <= '0;
            op_a_q        <= 2'b00;
            op_b_q        <= 2'b00;
            opcode_q      <= 3'b111;
            loop_sticky_q <= 1'b0;
            loop_count_q  <= 8'd0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= 2'b00;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rd_lat_q      <= rd_lat_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            opcode_q      <= opcode_d;
            loop_sticky_q <= loop_sticky_d;
            loop_count_q  <= loop_count_d;
            rf_q          <= rf_d;
        end
    end

    assign alu_op_a    = op_a_q;
    assign alu_op_b    = op_b_q;
    assign alu_opcode  = opcode_q;
    assign rd_data     = rf_view[rd_addr];
    assign fifo_count  = count_q;
    assign loop_sticky = loop_sticky_q;
    assign loop_count  = loop_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nyaya_dispatch.sv
// Self-checking bench for nyaya_dispatch: directed vector table, hand-written
// corner sequences and randomized batches checked against an in-order model.
module tb_nyaya_dispatch;

    localparam int DEPTH = 4;
    localparam int NREG  = 8;
    localparam int AW    = 3;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_opcode;
    logic [AW-1:0] in_ra, in_rb, in_rd;
    logic          flush;
    logic [1:0]    alu_op_a, alu_op_b;
    logic [2:0]    alu_opcode;
    logic [1:0]    alu_result;
    logic          alu_loop_flag;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [1:0]    ext_data;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_data;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          loop_sticky;
    logic [7:0]    loop_count;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural register file and loop status.
    logic [1:0] m_rf [NREG];
    int         m_loop;
    logic       m_sticky;
    logic [1:0] exp_q [$];

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] ra, rb, rd;
        logic [1:0]    a, b, res;
        string         name;
    } vec_t;
    vec_t vecs [9];

    nyaya_dispatch #(.DEPTH(DEPTH), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .flush(flush),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_loop_flag(alu_loop_flag),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .fifo_count(fifo_count), .loop_sticky(loop_sticky),
        .loop_count(loop_count), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural 4-valued ALU standing in for the downstream unit.
    function automatic logic [1:0] alu_f(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
        case (op)
            3'd0:    return (a > b) ? a : b;
            3'd1:    return (a < b) ? a : b;
            3'd2:    return a ^ 2'b01;
            3'd3:    return a ^ b;
            3'd4:    return (~a) | b;
            3'd5:    return ~(a ^ b);
            3'd6:    return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    assign alu_result = alu_f(alu_opcode, alu_op_a, alu_op_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic rf_check(input logic [AW-1:0] a, input logic [1:0] exp, input string name);
        rd_addr = a;
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic rf_dump(input string tag);
        logic [1:0] e;
        for (int a = 0; a < NREG; a++) exp_q.push_back(m_rf[a]);
        for (int a = 0; a < NREG; a++) begin
            e = exp_q.pop_front();
            rd_addr = AW'(a);
            #1;
            check($sformatf("%s_rf%0d", tag, a), 32'(rd_data), 32'(e));
        end
        @(negedge clk);
    endtask

    task automatic ext_write(input logic [AW-1:0] a, input logic [1:0] d);
        ext_we = 1'b1;
        ext_addr = a;
        ext_data = d;
        tick(1);
        ext_we = 1'b0;
        m_rf[a] = d;
    endtask

    // Leaves in_valid high so consecutive calls push back-to-back.
    task automatic push_instr(input logic [2:0] op, input logic [AW-1:0] ra,
                              input logic [AW-1:0] rb, input logic [AW-1:0] rd);
        int guard;
        in_opcode = op;
        in_ra = ra;
        in_rb = rb;
        in_rd = rd;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            tick(1);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
        end
        tick(1);
        m_rf[rd] = alu_f(op, m_rf[ra], m_rf[rb]);
        if (alu_loop_flag) begin
            m_sticky = 1'b1;
            if (m_loop < 255) m_loop++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_fifo_count"}, 32'(fifo_count), 0);
        check({tag, "_op_a"}, 32'(alu_op_a), 0);
        check({tag, "_op_b"}, 32'(alu_op_b), 0);
        check({tag, "_opcode"}, 32'(alu_opcode), 7);
        check({tag, "_sticky"}, 32'(loop_sticky), 0);
        check({tag, "_loop_count"}, 32'(loop_count), 0);
    endtask

    task automatic random_batch(input string tag);
        int n, k;
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) ext_write(AW'($urandom_range(0, NREG - 1)), 2'($urandom_range(0, 3)));
        alu_loop_flag = 1'($urandom_range(0, 1));
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++)
            push_instr(3'($urandom_range(0, 7)), AW'($urandom_range(0, NREG - 1)),
                       AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)));
        in_valid = 1'b0;
        tick(4 * n + 8);
        alu_loop_flag = 1'b0;
        check({tag, "_loop_count"}, 32'(loop_count), m_loop);
        check({tag, "_sticky"}, 32'(loop_sticky), 32'(m_sticky));
        check({tag, "_fifo_count"}, 32'(fifo_count), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        rf_dump(tag);
    endtask

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [1:0] old_v;
        vecs[0] = '{3'd0, 3'd1, 3'd2, 3'd3, 2'b01, 2'b10, 2'b10, "and"};
        vecs[1] = '{3'd1, 3'd4, 3'd5, 3'd6, 2'b11, 2'b01, 2'b01, "or"};
        vecs[2] = '{3'd2, 3'd7, 3'd0, 3'd1, 2'b11, 2'b00, 2'b10, "not_a"};
        vecs[3] = '{3'd3, 3'd2, 3'd3, 3'd4, 2'b10, 2'b11, 2'b01, "xor"};
        vecs[4] = '{3'd4, 3'd5, 3'd6, 3'd7, 2'b01, 2'b00, 2'b10, "impl"};
        vecs[5] = '{3'd5, 3'd0, 3'd0, 3'd2, 2'b10, 2'b10, 2'b11, "equiv"};
        vecs[6] = '{3'd6, 3'd3, 3'd1, 3'd5, 2'b00, 2'b11, 2'b10, "both"};
        vecs[7] = '{3'd7, 3'd6, 3'd7, 3'd0, 2'b01, 2'b01, 2'b11, "null"};
        vecs[8] = '{3'd0, 3'd1, 3'd4, 3'd6, 2'b11, 2'b00, 2'b11, "and_max"};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_opcode = 3'd0;
        in_ra = '0;
        in_rb = '0;
        in_rd = '0;
        flush = 1'b0;
        alu_loop_flag = 1'b0;
        ext_we = 1'b0;
        ext_addr = '0;
        ext_data = 2'b00;
        rd_addr = '0;
        for (int a = 0; a < NREG; a++) m_rf[a] = 2'b00;
        m_loop = 0;
        m_sticky = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rf_dump("reset");
        rst_n = 1'b1;
        tick(1);

        // Directed vectors: operands one cycle after push, writeback exactly 3 cycles after pop.
        for (int v = 0; v < 9; v++) begin
            ext_write(vecs[v].ra, vecs[v].a);
            ext_write(vecs[v].rb, vecs[v].b);
            old_v = m_rf[vecs[v].rd];
            push_instr(vecs[v].op, vecs[v].ra, vecs[v].rb, vecs[v].rd);
            in_valid = 1'b0;
            tick(1);
            check({vecs[v].name, "_op_a"}, 32'(alu_op_a), 32'(vecs[v].a));
            check({vecs[v].name, "_op_b"}, 32'(alu_op_b), 32'(vecs[v].b));
            check({vecs[v].name, "_opcode"}, 32'(alu_opcode), 32'(vecs[v].op));
            check({vecs[v].name, "_busy"}, 32'(busy), 1);
            tick(2);
            rf_check(vecs[v].rd, old_v, {vecs[v].name, "_pre_wb"});
            tick(1);
            rf_check(vecs[v].rd, vecs[v].res, {vecs[v].name, "_wb"});
            check({vecs[v].name, "_idle"}, 32'(busy), 0);
        end

        // Host write and pop on the same edge to the same register; host write while busy.
        ext_write(3'd1, 2'b01);
        in_opcode = 3'd1;
        in_ra = 3'd1;
        in_rb = 3'd1;
        in_rd = 3'd2;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        ext_we = 1'b1;
        ext_addr = 3'd1;
        ext_data = 2'b11;
        tick(1);
        ext_we = 1'b0;
        check("same_edge_op_a", 32'(alu_op_a), 1);
        rf_check(3'd1, 2'b11, "same_edge_ext");
        m_rf[2] = alu_f(3'd1, 2'b01, 2'b01);
        m_rf[1] = 2'b11;
        ext_we = 1'b1;
        ext_addr = 3'd7;
        ext_data = ~m_rf[7];
        tick(1);
        ext_we = 1'b0;
        rf_check(3'd7, m_rf[7], "ext_ignored_busy");
        tick(2);
        rf_check(3'd2, 2'b01, "same_edge_wb");

        // FIFO fill while an instruction is in flight.
        push_instr(3'd6, 3'd0, 3'd0, 3'd5);
        push_instr(3'd7, 3'd0, 3'd0, 3'd5);
        push_instr(3'd2, 3'd5, 3'd0, 3'd6);
        push_instr(3'd3, 3'd5, 3'd6, 3'd5);
        push_instr(3'd5, 3'd5, 3'd6, 3'd7);
        check("full_count", 32'(fifo_count), 4);
        check("full_in_ready", 32'(in_ready), 0);
        push_instr(3'd0, 3'd7, 3'd5, 3'd4);
        in_valid = 1'b0;
        tick(4 * 6 + 8);
        rf_dump("fill");

        // Dependent NOT_A chain on r0.
        ext_write(3'd0, 2'b00);
        for (int i = 0; i < 3; i++) push_instr(3'd2, 3'd0, 3'd0, 3'd0);
        in_valid = 1'b0;
        tick(4 * 3 + 8);
        rf_check(3'd0, 2'b01, "chain3");
        push_instr(3'd2, 3'd0, 3'd0, 3'd0);
        in_valid = 1'b0;
        tick(12);
        rf_check(3'd0, 2'b00, "chain4");

        // Flush during EXEC with two instructions queued; push on the flush edge is dropped.
        ext_write(3'd3, 2'b01);
        in_opcode = 3'd6; in_ra = 3'd0; in_rb = 3'd0; in_rd = 3'd3;
        in_valid = 1'b1;
        tick(1);
        in_opcode = 3'd7; in_rd = 3'd4;
        tick(1);
        in_rd = 3'd5;
        tick(1);
        check("flush_pre_count", 32'(fifo_count), 2);
        check("flush_pre_busy", 32'(busy), 1);
        flush = 1'b1;
        in_rd = 3'd6;
        tick(1);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 32'(fifo_count), 0);
        check("flush_busy", 32'(busy), 0);
        check("flush_in_ready", 32'(in_ready), 1);
        tick(8);
        check("flush_later_count", 32'(fifo_count), 0);
        rf_dump("flush");

        for (int b = 0; b < 15; b++) random_batch($sformatf("rand%0d", b));

        // Loop counter saturation over 300 writebacks.
        alu_loop_flag = 1'b1;
        for (int i = 0; i < 300; i++)
            push_instr(3'($urandom_range(0, 7)), AW'($urandom_range(0, NREG - 1)),
                       AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)));
        in_valid = 1'b0;
        tick(40);
        alu_loop_flag = 1'b0;
        check("sat_loop_count", 32'(loop_count), 255);
        check("sat_sticky", 32'(loop_sticky), 1);
        rf_dump("sat");

        // Asynchronous reset while in ISSUE.
        in_opcode = 3'd0; in_ra = 3'd1; in_rb = 3'd2; in_rd = 3'd3;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        for (int a = 0; a < NREG; a++) m_rf[a] = 2'b00;
        m_loop = 0;
        m_sticky = 1'b0;
        rf_dump("async_rst");
        rst_n = 1'b1;
        tick(6);
        rf_check(3'd3, 2'b00, "no_wb_after_rst");

        for (int b = 0; b < 3; b++) random_batch($sformatf("post%0d", b));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nyaya_dispatch.md
NYAYA_DISPATCH -- requirements
Module: nyaya_dispatch

Interface
REQ-001 Parameter DEPTH, default 4: instruction FIFO depth, power of two, 2..16.
REQ-002 Parameter NREG, default 8: N-Bit register file entries, 2 bits each; address width AW = 3 at default.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  FIFO can accept; a transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-007 in_opcode  input  3  ALU opcode: AND=000, OR=001, NOT_A=010, XOR=011, IMPL=100, EQUIV=101, BOTH=110, NULL=111.
REQ-008 in_ra, in_rb, in_rd  input  AW each  source A, source B and destination register addresses.
REQ-009 flush  input  1  synchronous; clears the FIFO and aborts any in-flight instruction.
REQ-010 alu_op_a, alu_op_b  output  2 each  registered operands to the downstream 4-valued ALU.
REQ-011 alu_opcode  output  3  registered opcode to the ALU.
REQ-012 alu_result  input  2  ALU registered result.
REQ-013 alu_loop_flag  input  1  ALU loop-detect flag.
REQ-014 ext_we, ext_addr[AW], ext_data[2]  inputs  host register-file write port.
REQ-015 rd_addr  input  AW; rd_data  output  2: combinational register-file read port.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.
REQ-017 fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 loop_sticky  output  1; loop_count  output  8: loop-event status.

Function
REQ-019 FIFO: in_ready = (fifo_count < DEPTH); a push while full cannot occur; push and pop in the same cycle leave the count unchanged.
REQ-020 FSM states: IDLE, ISSUE, EXEC, WB; each instruction takes exactly 3 cycles from pop to writeback.
REQ-021 IDLE: if the FIFO is non-empty and flush=0, pop the head, register alu_op_a=RF[ra], alu_op_b=RF[rb], alu_opcode=opcode and latch rd, then go to ISSUE.
REQ-022 ISSUE -> EXEC unconditionally; the ALU samples the operands on this edge.
REQ-023 EXEC -> WB unconditionally; alu_result becomes valid after this edge.
REQ-024 WB: write RF[rd] <= alu_result and return to IDLE; a new pop can occur in the very next IDLE cycle.
REQ-025 WB with alu_loop_flag=1: set loop_sticky and increment loop_count, saturating at 255; the writeback still occurs.
REQ-026 Operand hazards need no bypass logic, because each instruction's writeback completes before the next pop.
REQ-027 ext_we is honoured only while busy=0 and is ignored otherwise.
REQ-028 An ext write and a pop in the same cycle to the same register: the pop reads the old value; the write lands on that edge.
REQ-029 flush=1: FIFO emptied, FSM forced to IDLE, no writeback for the aborted instruction, register file and loop status unchanged; flush has priority over push.
REQ-030 alu_op_a, alu_op_b and alu_opcode hold their last values outside the pop edge.
REQ-031 Only the codes 00, 01, 10 and 11 exist: ASATYA, SATYA, UBHAYA, ANUBHAYA; values are stored unmodified.

Reset
REQ-032 rst_n low: FIFO empty, FSM in IDLE, all RF entries = ASATYA (00), alu_op_a = alu_op_b = 00, alu_opcode = 111, loop_sticky = 0, loop_count = 0, in_ready = 1, busy = 0.
REQ-033 Reset asserted mid-instruction discards that instruction without writeback; status resumes from reset values.

Verification
REQ-034 Set RF[1]=01 and RF[2]=10 via ext; push AND r1,r2 -> r3 -> alu_op_a=01 and alu_op_b=10 one cycle after push; RF[3]=10 (UBHAYA) 3 cycles after pop.
REQ-035 With the FSM held busy, push 5 instructions back-to-back -> in_ready drops after the 4th push (fifo_count=4); all 4 execute in order, 3 cycles each.
REQ-036 Chain NOT_A r0 -> r0 four times from RF[0]=00 -> final RF[0]=00; each read sees the prior writeback.
REQ-037 Drive alu_loop_flag=1 during 300 WB cycles -> loop_sticky=1 and loop_count=255.
REQ-038 Assert flush in EXEC with 2 instructions queued -> no RF change, fifo_count=0, busy=0 on the next cycle.
REQ-039 Pulse rst_n low during ISSUE -> all outputs return to their REQ-032 values immediately, asynchronously.
